// File: rtl/ipg_rx_extract.sv
// Receive-side IPG message extractor: pulls message bits out of control-block
// IDLE slots, reassembles 520-bit messages MSB-first and scrubs the slots back to IDLE.
module ipg_rx_extract #(
    parameter int MSG_WIDTH = 520,
    parameter int CNT_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           encoded_rx_hdr,
    input  logic [63:0]          encoded_rx_data,
    output logic [1:0]           proced_encoded_rx_hdr,
    output logic [63:0]          proced_encoded_rx_data,
    output logic [MSG_WIDTH-1:0] ipg_msg,
    output logic                 ipg_msg_valid,
    output logic [CNT_WIDTH-1:0] rx_payload_count,
    output logic [6:0]           rx_len
);

    // state      | meaning
    // ST_COLLECT | consuming slot bits into the accumulator
    // ST_GAP     | message done; next eligible slot is discarded, then restart
    typedef enum logic {ST_COLLECT, ST_GAP} state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [MSG_WIDTH-1:0] acc_q, acc_d, msg_d;
    logic                 valid_d;

    logic                 eligible;
    logic [5:0]           slot_hi;
    logic [6:0]           slot_len;
    logic [63:0]          len_mask;
    logic [63:0]          slot_mask;
    logic [63:0]          slot_al;
    logic [MSG_WIDTH-1:0] slot_ext;
    logic [MSG_WIDTH-1:0] slot_placed;
    logic [CNT_WIDTH-1:0] len_ext;

    always_comb begin
        eligible = 1'b0;
        slot_hi  = 6'd0;
        slot_len = 7'd0;
        if (encoded_rx_hdr == 2'b01) begin
            eligible = 1'b1;
            case (encoded_rx_data[7:0])
                8'h1e: begin slot_hi = 6'd63; slot_len = 7'd56; end
                8'h2d: begin slot_hi = 6'd31; slot_len = 7'd24; end
                8'h33: begin slot_hi = 6'd31; slot_len = 7'd24; end
                8'h4b: begin slot_hi = 6'd63; slot_len = 7'd24; end
                8'h87: begin slot_hi = 6'd63; slot_len = 7'd48; end
                8'h99: begin slot_hi = 6'd63; slot_len = 7'd40; end
                8'haa: begin slot_hi = 6'd63; slot_len = 7'd32; end
                8'hb4: begin slot_hi = 6'd63; slot_len = 7'd24; end
                8'hcc: begin slot_hi = 6'd63; slot_len = 7'd16; end
                8'hd2: begin slot_hi = 6'd63; slot_len = 7'd8;  end
                default: eligible = 1'b0;
            endcase
        end
    end

    // Slot is left-justified to bit 63, then dropped into the message so its MSB lands at R-1.
    assign len_mask    = eligible ? ({64{1'b1}} << (7'd64 - slot_len)) : 64'd0;
    assign slot_mask   = len_mask >> (6'd63 - slot_hi);
    assign slot_al     = (encoded_rx_data << (6'd63 - slot_hi)) & len_mask;
    assign slot_ext    = {slot_al, {(MSG_WIDTH-64){1'b0}}};
    assign slot_placed = slot_ext >> (CNT_WIDTH'(MSG_WIDTH) - rx_payload_count);
    assign len_ext     = CNT_WIDTH'(slot_len);

    always_comb begin
        state_d = state_q;
        cnt_d   = rx_payload_count;
        acc_d   = acc_q;
        msg_d   = ipg_msg;
        valid_d = 1'b0;
        if (eligible) begin
            case (state_q)
                ST_COLLECT: begin
                    if (len_ext < rx_payload_count) begin
                        acc_d = acc_q | slot_placed;
                        cnt_d = rx_payload_count - len_ext;
                    end else begin
                        msg_d   = acc_q | slot_placed;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_GAP;
                    end
                end
                ST_GAP: begin
                    acc_d   = '0;
                    cnt_d   = CNT_WIDTH'(MSG_WIDTH);
                    state_d = ST_COLLECT;
                end
                default: state_d = ST_COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q                <= ST_COLLECT;
            acc_q                  <= '0;
            ipg_msg                <= '0;
            ipg_msg_valid          <= 1'b0;
            rx_payload_count       <= CNT_WIDTH'(MSG_WIDTH);
            rx_len                 <= 7'd0;
            proced_encoded_rx_hdr  <= 2'b00;
            proced_encoded_rx_data <= 64'd0;
        end else begin
            state_q                <= state_d;
            acc_q                  <= acc_d;
            ipg_msg                <= msg_d;
            ipg_msg_valid          <= valid_d;
            rx_payload_count       <= cnt_d;
            rx_len                 <= slot_len;
            proced_encoded_rx_hdr  <= encoded_rx_hdr;
            proced_encoded_rx_data <= encoded_rx_data & ~slot_mask;
        end
    end

endmodule

// File: tb/tb_ipg_rx_extract.sv
// Randomized bench for ipg_rx_extract against a bit-level reference model of
// the slot extraction, gap and scrubbing rules.
module tb_ipg_rx_extract;
    localparam int MW = 520;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    enc_hdr = 2'b00;
    logic [63:0]   enc_data = 64'd0;
    logic [1:0]    out_hdr;
    logic [63:0]   out_data;
    logic [MW-1:0] ipg_msg;
    logic          ipg_msg_valid;
    logic [CW-1:0] rx_payload_count;
    logic [6:0]    rx_len;

    ipg_rx_extract #(.MSG_WIDTH(MW), .CNT_WIDTH(CW)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .encoded_rx_hdr         (enc_hdr),
        .encoded_rx_data        (enc_data),
        .proced_encoded_rx_hdr  (out_hdr),
        .proced_encoded_rx_data (out_data),
        .ipg_msg                (ipg_msg),
        .ipg_msg_valid          (ipg_msg_valid),
        .rx_payload_count       (rx_payload_count),
        .rx_len                 (rx_len)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // eligible block types: code, slot MSB position, slot width
    logic [7:0] types [10] = '{8'h1e, 8'h2d, 8'h33, 8'h4b, 8'h87, 8'h99, 8'haa, 8'hb4, 8'hcc, 8'hd2};
    int         his   [10] = '{63, 31, 31, 63, 63, 63, 63, 63, 63, 63};
    int         lens  [10] = '{56, 24, 24, 24, 48, 40, 32, 24, 16, 8};
    logic [7:0] bad_types [6] = '{8'h78, 8'h66, 8'h55, 8'he1, 8'hff, 8'h00};

    // reference model state
    bit            m_gap;
    int            m_rem;
    logic [MW-1:0] m_acc, m_msg;
    logic [1:0]    e_hdr;
    logic [63:0]   e_data;
    logic          e_valid;
    int            e_len;

    logic [MW-1:0] src;
    int            src_ptr;

    task automatic chk(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model(input logic r, input logic [1:0] h, input logic [63:0] d);
        int idx, take;
        if (r) begin
            m_gap = 0; m_rem = MW; m_acc = '0; m_msg = '0;
            e_hdr = 2'b00; e_data = 64'd0; e_valid = 1'b0; e_len = 0;
            return;
        end
        idx = -1;
        if (h == 2'b01)
            for (int k = 0; k < 10; k++) if (d[7:0] == types[k]) idx = k;
        e_hdr = h; e_data = d; e_valid = 1'b0; e_len = 0;
        if (idx < 0) return;
        e_len = lens[idx];
        for (int i = 0; i < lens[idx]; i++) e_data[his[idx]-i] = 1'b0;
        if (m_gap) begin
            m_gap = 0; m_rem = MW; m_acc = '0;
        end else begin
            take = (lens[idx] < m_rem) ? lens[idx] : m_rem;
            for (int i = 0; i < take; i++) m_acc[m_rem-1-i] = d[his[idx]-i];
            if (lens[idx] >= m_rem) begin
                m_msg = m_acc; e_valid = 1'b1; m_rem = 0; m_gap = 1;
            end else begin
                m_rem = m_rem - lens[idx];
            end
        end
    endtask

    task automatic step(input logic r, input logic [1:0] h, input logic [63:0] d);
        @(negedge clk);
        rst = r; enc_hdr = h; enc_data = d;
        model(r, h, d);
        @(posedge clk);
        #1;
        chk("hdr",   MW'(out_hdr),          MW'(e_hdr));
        chk("data",  MW'(out_data),         MW'(e_data));
        chk("count", MW'(rx_payload_count), MW'(m_rem));
        chk("len",   MW'(rx_len),           MW'(e_len));
        chk("valid", MW'(ipg_msg_valid),    MW'(e_valid));
        chk("msg",   ipg_msg,               m_msg);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic send_noise();
        logic [63:0] d;
        d = rnd64();
        case ($urandom_range(0, 2))
            0: step(0, 2'b10, d);
            1: step(0, ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00, d);
            default: begin
                d[7:0] = bad_types[$urandom_range(0, 5)];
                step(0, 2'b01, d);
            end
        endcase
    endtask

    task automatic send_payload(input int idx);
        logic [63:0] d;
        int take;
        d = rnd64();
        d[7:0] = types[idx];
        for (int i = 0; i < lens[idx]; i++)
            if (src_ptr - 1 - i >= 0) d[his[idx]-i] = src[src_ptr-1-i];
        take = (lens[idx] < src_ptr) ? lens[idx] : src_ptr;
        src_ptr -= take;
        step(0, 2'b01, d);
    endtask

    // mode 0: CTRL only, 1: random mix, 2: exact fit, 3: partial TERM_1, 4: directed mixed
    task automatic send_message(input int mode);
        int k, idx;
        int seq4 [4] = '{9, 8, 3, 4};
        for (int i = 0; i < MW; i++) src[i] = 1'($urandom_range(0, 1));
        src_ptr = MW;
        k = 0;
        while (src_ptr > 0 && k < 200) begin
            case (mode)
                0: idx = 0;
                1: idx = $urandom_range(0, 9);
                2: idx = (src_ptr > 16) ? 0 : 8;
                3: idx = (src_ptr == MW) ? 9 : ((src_ptr == 8) ? 5 : 0);
                default: idx = (k < 4) ? seq4[k] : 0;
            endcase
            if (mode == 1 && $urandom_range(0, 2) == 0) send_noise();
            if (mode == 4 && k > 0 && k < 5) step(0, 2'b10, 64'hDEADBEEF_DEADBEEF);
            send_payload(idx);
            k++;
        end
        chk("msg_src", ipg_msg, src);
        if (mode == 0) begin
            step(0, 2'b01, {56'hFF_FFFF_FFFF_FFFF, 8'h1e});
            chk("gap_scrub", MW'(out_data), MW'(64'h1e));
        end else begin
            if ($urandom_range(0, 1) != 0) send_noise();
            idx = $urandom_range(0, 9);
            step(0, 2'b01, {rnd64() >> 8, types[idx]});
        end
    endtask

    initial begin
        logic [63:0] d;
        step(1, 2'b01, rnd64());
        step(1, 2'b10, rnd64());

        send_message(0);
        send_message(0);
        send_message(4);
        send_message(3);
        send_message(2);

        for (int i = 0; i < MW; i++) src[i] = 1'($urandom_range(0, 1));
        src_ptr = MW;
        for (int i = 0; i < 4; i++) send_payload(0);
        step(1, 2'b01, {56'h12_3456_789A_BCDE, 8'h1e});
        chk("rst_count", MW'(rx_payload_count), MW'(MW));
        send_message(0);

        d = rnd64();
        step(0, 2'b11, d);
        d[7:0] = 8'hff;
        step(0, 2'b01, d);
        chk("bad_type_pass", MW'(out_data), MW'(d));

        for (int i = 0; i < 8; i++) send_message(1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
